// File: rtl/nott_sched_pkg.sv
// Shared types and widths for the NOTT pulse scheduler.
package nott_sched_pkg;

  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned IDW           = $clog2(N_REQ_DEFAULT);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SEND_A  = 3'd2,
    ST_WAIT_A  = 3'd3,
    ST_FIRE    = 3'd4,
    ST_RECOVER = 3'd5,
    ST_ACK     = 3'd6
  } state_e;

  // States in which the granted requester owns the cell.
  function automatic logic holds_grant(state_e s);
    return (s == ST_SEND_A) || (s == ST_WAIT_A) || (s == ST_FIRE) ||
           (s == ST_RECOVER) || (s == ST_ACK);
  endfunction

endpackage

// File: rtl/nott_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module nott_rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any_c,
  output logic [N_REQ-1:0] onehot_c,
  output logic [ID_W-1:0]  idx_c
);

  logic [ID_W-1:0] cand;

  always_comb begin
    any_c    = 1'b0;
    onehot_c = '0;
    idx_c    = '0;
    cand     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % N_REQ);
      if (!any_c && req[cand]) begin
        any_c          = 1'b1;
        idx_c          = cand;
        onehot_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nott_pulse_scheduler.sv
// Shares one clocked-inverter cell among N_REQ requesters: round-robin grant,
// timed a/clk pulse sequencing, and a shadow model of the cell's output.
module nott_pulse_scheduler import nott_sched_pkg::*; #(
  parameter  int unsigned N_REQ       = N_REQ_DEFAULT,
  parameter  int unsigned A_TO_CLK    = 2,
  parameter  int unsigned CLK_RECOVER = 3,
  parameter  int unsigned INIT_CYCLES = 8,
  parameter  int unsigned CW          = 8,
  localparam int unsigned ID_W        = (N_REQ == N_REQ_DEFAULT) ? IDW : $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_data,
  output logic [N_REQ-1:0] gnt,
  output logic             ack_valid,
  output logic [ID_W-1:0]  ack_id,
  output logic             ack_result,
  output logic             nott_a,
  output logic             nott_clk,
  output logic             nott_q_shadow,
  output logic             busy
);

  localparam logic [CW-1:0] INIT_LOAD    = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] A_LOAD       = CW'((A_TO_CLK > 0) ? A_TO_CLK - 1 : 0);
  localparam logic [CW-1:0] RECOVER_LOAD = CW'((CLK_RECOVER > 0) ? CLK_RECOVER - 1 : 0);

  state_e           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [ID_W-1:0]  ptr_q, ptr_n;
  logic [ID_W-1:0]  id_q, id_n;
  logic [N_REQ-1:0] sel_q, sel_n;
  logic             data_q, data_n;
  logic             sh_state_q, sh_state_n;
  logic             sh_q_q, sh_q_n;
  logic             res_q, res_n;

  logic [N_REQ-1:0] gnt_n;
  logic             ack_valid_n, ack_result_n, nott_a_n, nott_clk_n, busy_n;
  logic [ID_W-1:0]  ack_id_n;

  logic             arb_any_c;
  logic [N_REQ-1:0] arb_onehot_c;
  logic [ID_W-1:0]  arb_idx_c;

  nott_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .any_c    (arb_any_c),
    .onehot_c (arb_onehot_c),
    .idx_c    (arb_idx_c)
  );

  // Next-state, counter, latch and shadow-cell update.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    ptr_n      = ptr_q;
    id_n       = id_q;
    sel_n      = sel_q;
    data_n     = data_q;
    sh_state_n = sh_state_q;
    sh_q_n     = sh_q_q;
    res_n      = res_q;

    unique case (state_q)
      ST_INIT: begin
        if (cnt_q <= CW'(1)) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      ST_IDLE: begin
        if (arb_any_c) begin
          id_n    = arb_idx_c;
          sel_n   = arb_onehot_c;
          data_n  = req_data[arb_idx_c];
          state_n = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        if (data_q) sh_state_n = 1'b1;
        if (A_TO_CLK == 0) begin
          state_n = ST_FIRE;
        end else begin
          cnt_n   = A_LOAD;
          state_n = ST_WAIT_A;
        end
      end
      ST_WAIT_A: begin
        if (cnt_q == '0) state_n = ST_FIRE;
        else             cnt_n   = cnt_q - CW'(1);
      end
      ST_FIRE: begin
        // A clk pulse with no pending a flips the cell output; otherwise it only clears the stored a.
        if (!sh_state_q) begin
          sh_q_n = ~sh_q_q;
          res_n  = 1'b1;
        end else begin
          sh_state_n = 1'b0;
          res_n      = 1'b0;
        end
        if (CLK_RECOVER == 0) begin
          state_n = ST_ACK;
        end else begin
          cnt_n   = RECOVER_LOAD;
          state_n = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) state_n = ST_ACK;
        else             cnt_n   = cnt_q - CW'(1);
      end
      ST_ACK: begin
        if (32'(id_q) == N_REQ - 1) ptr_n = '0;
        else                        ptr_n = id_q + ID_W'(1);
        state_n = ST_IDLE;
      end
      default: begin
        cnt_n   = INIT_LOAD;
        state_n = ST_INIT;
      end
    endcase
  end

  // Moore decode of the upcoming state, registered into the outputs.
  always_comb begin
    gnt_n        = '0;
    ack_valid_n  = 1'b0;
    ack_id_n     = '0;
    ack_result_n = 1'b0;
    nott_a_n     = 1'b0;
    nott_clk_n   = 1'b0;
    busy_n       = (state_n != ST_IDLE);

    if (holds_grant(state_n)) gnt_n = sel_n;
    if (state_n == ST_SEND_A) nott_a_n   = data_n;
    if (state_n == ST_FIRE)   nott_clk_n = 1'b1;
    if (state_n == ST_ACK) begin
      ack_valid_n  = 1'b1;
      ack_id_n     = id_n;
      ack_result_n = res_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= INIT_LOAD;
      ptr_q      <= '0;
      id_q       <= '0;
      sel_q      <= '0;
      data_q     <= 1'b0;
      sh_state_q <= 1'b0;
      sh_q_q     <= 1'b0;
      res_q      <= 1'b0;
      gnt        <= '0;
      ack_valid  <= 1'b0;
      ack_id     <= '0;
      ack_result <= 1'b0;
      nott_a     <= 1'b0;
      nott_clk   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      ptr_q      <= ptr_n;
      id_q       <= id_n;
      sel_q      <= sel_n;
      data_q     <= data_n;
      sh_state_q <= sh_state_n;
      sh_q_q     <= sh_q_n;
      res_q      <= res_n;
      gnt        <= gnt_n;
      ack_valid  <= ack_valid_n;
      ack_id     <= ack_id_n;
      ack_result <= ack_result_n;
      nott_a     <= nott_a_n;
      nott_clk   <= nott_clk_n;
      busy       <= busy_n;
    end
  end

  assign nott_q_shadow = sh_q_q;

endmodule
